// File: rtl/eh2_dccm_rmw_seq_pkg.sv
// Shared types and constants for the DCCM read-modify-write sequencer.
package eh2_dccm_rmw_pkg;

  localparam int unsigned ECC_DATA_W  = 32;
  localparam int unsigned ECC_HAM_W   = 6;
  localparam int unsigned ECC_W       = 7;
  localparam int unsigned ECC_FDATA_W = 39;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CHK,
    WR
  } state_t;

  // Hamming codeword position (1-based) of data bit k; powers of two hold check bits.
  function automatic logic [5:0] data_pos(input int unsigned k);
    logic [5:0] pos;
    int unsigned n;
    pos = '0;
    n   = 0;
    for (int unsigned p = 3; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) pos = p[5:0];
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/eh2_dccm_rmw_seq_if.sv
// Store request handshake between the core and the RMW sequencer.
interface eh2_dccm_rmw_seq_if #(
  parameter int DCCM_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [DCCM_BITS-1:0] req_addr;
  logic [3:0]           req_byteen;
  logic [31:0]          req_data;

  modport master (
    output req_valid, req_addr, req_byteen, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_byteen, req_data,
    output req_ready
  );
endinterface

// File: rtl/eh2_dccm_rmw_seq_secded.sv
// Combinational 32-bit SECDED: encode of data, plus decode/correct of data against ecc_in.
module eh2_dccm_secded
  import eh2_dccm_rmw_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data,
  input  logic [ECC_W-1:0]      ecc_in,
  output logic [ECC_W-1:0]      ecc_out,
  output logic [ECC_DATA_W-1:0] data_corr,
  output logic                  single_err,
  output logic                  double_err
);

  logic [ECC_HAM_W-1:0] ham;
  logic [ECC_HAM_W-1:0] syndrome;
  logic                 parity;

  // Hamming check bits: bit b covers every data bit whose position has bit b set.
  always_comb begin
    logic [5:0] pos;
    ham = '0;
    for (int unsigned k = 0; k < ECC_DATA_W; k++) begin
      pos = data_pos(k);
      for (int unsigned b = 0; b < ECC_HAM_W; b++) begin
        if (pos[b]) ham[b] = ham[b] ^ data[k];
      end
    end
    ecc_out = {^{data, ham}, ham};
  end

  // Overall parity separates odd (correctable) from even (uncorrectable) error counts.
  always_comb begin
    syndrome   = ham ^ ecc_in[ECC_HAM_W-1:0];
    parity     = ^{data, ecc_in};
    single_err = parity;
    double_err = !parity && (syndrome != '0);
    data_corr  = data;
    for (int unsigned k = 0; k < ECC_DATA_W; k++) begin
      if (single_err && (syndrome == data_pos(k))) data_corr[k] = ~data[k];
    end
  end

endmodule

// File: rtl/eh2_dccm_rmw_seq.sv
// DCCM read-modify-write sequencer: partial stores read/correct/merge/re-encode, full stores write directly.
module eh2_dccm_rmw_seq
  import eh2_dccm_rmw_pkg::*;
#(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_DATA_WIDTH  = 32,
  parameter int DCCM_ECC_WIDTH   = 7,
  parameter int DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst,
  eh2_dccm_rmw_seq_if.slave           req,
  input  logic                        ecc_disable,
  input  logic                        dccm_grant,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data,
  output logic                        sb_err,
  output logic                        db_err,
  output logic                        busy
);

  state_t                      state_q, state_d;
  logic [DCCM_BITS-1:0]        addr_q;
  logic [3:0]                  byteen_q;
  logic [DCCM_DATA_WIDTH-1:0]  data_q;
  logic [DCCM_DATA_WIDTH-1:0]  word_q;
  logic [DCCM_DATA_WIDTH-1:0]  dec_corr;
  logic                        dec_single, dec_double;
  logic [DCCM_DATA_WIDTH-1:0]  rd_word;
  logic [DCCM_DATA_WIDTH-1:0]  merged;
  logic [DCCM_ECC_WIDTH-1:0]   enc_ecc;
  logic                        accept;
  logic                        drop;

  logic [DCCM_ECC_WIDTH-1:0]   unused_dec_ecc;
  logic [DCCM_DATA_WIDTH-1:0]  unused_enc_corr;
  logic                        unused_enc_single, unused_enc_double;

  eh2_dccm_secded u_dec (
    .data       (dccm_rd_data[DCCM_DATA_WIDTH-1:0]),
    .ecc_in     (dccm_rd_data[DCCM_FDATA_WIDTH-1:DCCM_DATA_WIDTH]),
    .ecc_out    (unused_dec_ecc),
    .data_corr  (dec_corr),
    .single_err (dec_single),
    .double_err (dec_double)
  );

  eh2_dccm_secded u_enc (
    .data       (word_q),
    .ecc_in     ('0),
    .ecc_out    (enc_ecc),
    .data_corr  (unused_enc_corr),
    .single_err (unused_enc_single),
    .double_err (unused_enc_double)
  );

  assign accept = (state_q == IDLE) && req.req_valid;
  assign drop   = dec_double && !ecc_disable;

  // Byte merge of store data over the (corrected or raw) read word.
  always_comb begin
    rd_word = ecc_disable ? dccm_rd_data[DCCM_DATA_WIDTH-1:0] : dec_corr;
    merged  = rd_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byteen_q[i]) merged[8*i +: 8] = data_q[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req.req_valid) state_d = (req.req_byteen == 4'hF) ? WR : RD;
      RD:   if (dccm_grant) state_d = CHK;
      CHK:  state_d = drop ? IDLE : WR;
      WR:   if (dccm_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables and pulses are decoded from state so a reset can never leave a write half issued.
  always_comb begin
    req.req_ready = (state_q == IDLE);
    busy          = (state_q != IDLE);
    dccm_rden     = (state_q == RD) && dccm_grant;
    dccm_wren     = (state_q == WR) && dccm_grant;
    sb_err        = (state_q == CHK) && !ecc_disable && dec_single;
    db_err        = (state_q == CHK) && drop;
  end

  // Captured request and write word; word_q takes store data directly or the merged RMW result.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      byteen_q <= '0;
      data_q   <= '0;
      word_q   <= '0;
    end else if (accept) begin
      addr_q   <= {req.req_addr[DCCM_BITS-1:2], 2'b00};
      byteen_q <= req.req_byteen;
      data_q   <= req.req_data;
      word_q   <= req.req_data;
    end else if ((state_q == CHK) && !drop) begin
      word_q   <= merged;
    end
  end

  assign dccm_rd_addr = addr_q;
  assign dccm_wr_addr = addr_q;
  assign dccm_wr_data = {enc_ecc, word_q};

endmodule

// File: tb/tb_eh2_dccm_rmw_seq.sv
// Scoreboard bench for eh2_dccm_rmw_seq with a word-array memory model.
module tb_eh2_dccm_rmw_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ecc_disable = 1'b0;
  logic        dccm_grant = 1'b1;
  logic        dccm_rden, dccm_wren, sb_err, db_err, busy;
  logic [15:0] dccm_rd_addr, dccm_wr_addr;
  logic [38:0] dccm_rd_data = '0;
  logic [38:0] dccm_wr_data;

  always #5 clk = ~clk;

  eh2_dccm_rmw_seq_if #(.DCCM_BITS(16)) rq ();

  eh2_dccm_rmw_seq #(
    .DCCM_BITS(16), .DCCM_DATA_WIDTH(32), .DCCM_ECC_WIDTH(7), .DCCM_FDATA_WIDTH(39)
  ) dut (
    .clk(clk), .rst(rst), .req(rq.slave), .ecc_disable(ecc_disable), .dccm_grant(dccm_grant),
    .dccm_rden(dccm_rden), .dccm_rd_addr(dccm_rd_addr), .dccm_rd_data(dccm_rd_data),
    .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .sb_err(sb_err), .db_err(db_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rden_count = 0;
  int last_c0 = 0;
  bit stall_en = 0;
  bit rand_grant = 0;
  logic [31:0] cur_flip = '0;
  logic [31:0] mem [16384];

  typedef struct { logic [15:0] addr; logic [38:0] data; int at; } wr_exp_t;
  typedef struct { bit dbl; int at; } pl_exp_t;
  wr_exp_t wq[$];
  pl_exp_t pq[$];

  // Check bits from codeword positions: XOR of the positions of all set data bits gives the Hamming part.
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [5:0] h;
    int unsigned k;
    h = '0;
    k = 0;
    for (int unsigned p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) h = h ^ p[5:0];
        k++;
      end
    end
    return {(^d) ^ (^h), h};
  endfunction

  function automatic logic [38:0] enc(input logic [31:0] d);
    return {ref_ecc(d), d};
  endfunction

  function automatic logic [31:0] merge(input logic [3:0] be, input logic [31:0] st, input logic [31:0] old);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (st & m) | (old & ~m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Grant pattern for the new cycle: scripted stall, random, or always granted.
  always @(posedge clk) begin
    int n;
    #1;
    n = cyc - last_c0;
    if (stall_en)        dccm_grant = !(n == 1 || n == 2 || n == 5 || n == 6 || n == 7);
    else if (rand_grant) dccm_grant = ($urandom_range(0, 3) != 0);
    else                 dccm_grant = 1'b1;
  end

  // Memory read port: data appears the cycle after the read enable, with injected flips.
  always @(negedge clk) begin
    logic [31:0] w;
    if (dccm_rden) begin
      w = mem[dccm_rd_addr[15:2]];
      @(posedge clk);
      #1 dccm_rd_data = {ref_ecc(w), w ^ cur_flip};
    end
  end

  // Monitor: pops expected writes and error pulses whenever the DUT presents them.
  always @(negedge clk) begin
    wr_exp_t we;
    pl_exp_t pe;
    if (dccm_rden) rden_count++;
    if (dccm_rden || dccm_wren) chk("rd_wr_overlap", 64'(dccm_rden & dccm_wren), 64'd0);
    if (dccm_wren) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write", dccm_wr_addr, dccm_wr_data);
      end else begin
        we = wq.pop_front();
        chk("wr_addr", 64'(dccm_wr_addr), 64'(we.addr));
        chk("wr_data", 64'(dccm_wr_data), 64'(we.data));
        if (we.at >= 0) chk("wr_cycle", 64'(cyc), 64'(we.at));
        mem[we.addr[15:2]] = we.data[31:0];
      end
    end
    if (sb_err || db_err) begin
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_err_pulse actual sb=%0b db=%0b expected none", sb_err, db_err);
      end else begin
        pe = pq.pop_front();
        chk("err_kind", 64'({sb_err, db_err}), pe.dbl ? 64'd1 : 64'd2);
        if (pe.at >= 0) chk("err_cycle", 64'(cyc), 64'(pe.at));
      end
    end
  end

  // Issue one store at a negedge with ready, pushing the model's expected response.
  task automatic issue(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data,
                       input logic [31:0] flip, input logic ecc_dis, input int wr_lat,
                       input int pl_lat, input bit abandon);
    int t;
    int c0;
    logic [31:0] orig, raw;
    int nflip;
    t = 0;
    @(negedge clk);
    while (!rq.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rq.req_ready) chk("req_ready_timeout", 64'(rq.req_ready), 64'd1);
    c0 = cyc;
    last_c0 = c0;
    cur_flip = flip;
    ecc_disable = ecc_dis;
    rq.req_valid = 1'b1;
    rq.req_addr = addr;
    rq.req_byteen = be;
    rq.req_data = data;
    if (!abandon) begin
      orig = mem[addr[15:2]];
      nflip = $countones(flip);
      if (be == 4'hF) begin
        wq.push_back('{addr & 16'hFFFC, enc(data), (wr_lat >= 0) ? c0 + wr_lat : -1});
      end else if (!ecc_dis && nflip == 2) begin
        pq.push_back('{1'b1, (pl_lat >= 0) ? c0 + pl_lat : -1});
      end else begin
        raw = ecc_dis ? (orig ^ flip) : orig;
        if (!ecc_dis && nflip == 1) pq.push_back('{1'b0, (pl_lat >= 0) ? c0 + pl_lat : -1});
        wq.push_back('{addr & 16'hFFFC, enc(merge(be, data, raw)), (wr_lat >= 0) ? c0 + wr_lat : -1});
      end
    end
    @(posedge clk);
    #1 rq.req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rq.req_ready && n < 200);
    if (lat >= 0) chk(name, 64'(n), 64'(lat));
    else          chk(name, 64'(rq.req_ready), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rden"}, 64'(dccm_rden), 64'd0);
    chk({tag, "_wren"}, 64'(dccm_wren), 64'd0);
    chk({tag, "_sb"}, 64'(sb_err), 64'd0);
    chk({tag, "_db"}, 64'(db_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_addr"}, 64'(dccm_rd_addr), 64'd0);
    chk({tag, "_wr_addr"}, 64'(dccm_wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(dccm_wr_data), 64'd0);
    chk({tag, "_ready"}, 64'(rq.req_ready), 64'd1);
  endtask

  initial begin
    int rc0;
    logic [31:0] d, exp_word;
    logic [31:0] flip;
    int b1, b2, r;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    rq.req_valid = 1'b0;
    rq.req_addr = '0;
    rq.req_byteen = '0;
    rq.req_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(rq.req_ready), 64'd1);

    // Full-word store: write in cycle 1, no read, ready in cycle 2.
    rc0 = rden_count;
    issue(16'h0040, 4'hF, 32'hDEADBEEF, '0, 1'b0, 1, -1, 1'b0);
    wait_ready(2, "full_ready_lat");
    chk("full_no_rden", 64'(rden_count), 64'(rc0));

    // Partial store over a clean word.
    mem[16'h0080 >> 2] = 32'h11223344;
    issue(16'h0080, 4'b0010, 32'h0000AA00, '0, 1'b0, 3, -1, 1'b0);
    wait_ready(4, "partial_ready_lat");

    // Single-bit error on data bit 5.
    mem[16'h0090 >> 2] = 32'hA5A5_5A5A;
    issue(16'h0090, 4'b0001, 32'h0000_00FF, 32'h1 << 5, 1'b0, 3, 2, 1'b0);
    wait_ready(4, "sb_ready_lat");

    // Double-bit error: store dropped, ready in cycle 3.
    issue(16'h00A0, 4'b0001, 32'h0000_0077, (32'h1 << 3) | (32'h1 << 9), 1'b0, -1, 2, 1'b0);
    wait_ready(3, "db_ready_lat");

    // Same double flip with ECC disabled: raw merge, no pulses.
    issue(16'h00A0, 4'b0001, 32'h0000_0077, (32'h1 << 3) | (32'h1 << 9), 1'b1, 3, -1, 1'b0);
    wait_ready(4, "eccdis_ready_lat");

    // Grant stall: 2 stalled cycles in RD, 3 in WR, write lands in cycle 8.
    d = $urandom;
    exp_word = merge(4'b0101, d, mem[16'h0100 >> 2]);
    stall_en = 1'b1;
    issue(16'h0101, 4'b0101, d, '0, 1'b0, 8, -1, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk("stall_rden", 64'(dccm_rden), 64'(n == 3));
      chk("stall_wren", 64'(dccm_wren), 64'(n == 8));
      if (n <= 3) chk("stall_rd_addr", 64'(dccm_rd_addr), 64'h0100);
      if (n >= 5) begin
        chk("stall_wr_addr", 64'(dccm_wr_addr), 64'h0100);
        chk("stall_wr_data", 64'(dccm_wr_data), 64'(enc(exp_word)));
      end
    end
    @(negedge clk);
    chk("stall_ready", 64'(rq.req_ready), 64'd1);
    @(posedge clk);
    #1 stall_en = 1'b0;

    // Reset while in CHK abandons the store; a request during reset is ignored.
    issue(16'h00C0, 4'b1000, $urandom, '0, 1'b0, -1, -1, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 begin
      rq.req_valid = 1'b1;
      rq.req_addr = 16'h00D0;
      rq.req_byteen = 4'hF;
      rq.req_data = 32'h1234_5678;
    end
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1 begin
      rst = 1'b0;
      rq.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("req_during_rst_ignored", 64'(busy), 64'd0);
    issue(16'h00C4, 4'hF, 32'hCAFE_F00D, '0, 1'b0, 1, -1, 1'b0);
    wait_ready(2, "post_reset_ready_lat");

    // Randomized traffic with random grant.
    rand_grant = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      b1 = $urandom_range(0, 31);
      b2 = (b1 + $urandom_range(1, 31)) % 32;
      if (r < 6)      flip = '0;
      else if (r < 8) flip = 32'h1 << b1;
      else            flip = (32'h1 << b1) | (32'h1 << b2);
      issue(16'($urandom_range(0, 255)), 4'($urandom_range(1, 15)), $urandom, flip,
            ($urandom_range(0, 4) == 0), -1, -1, 1'b0);
      wait_ready(-1, "rand_ready");
    end
    rand_grant = 1'b0;

    repeat (5) @(negedge clk);
    chk("pending_writes", 64'(wq.size()), 64'd0);
    chk("pending_pulses", 64'(pq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eh2_dccm_rmw_seq.md
# eh2_dccm_rmw_seq

Read-modify-write sequencer upstream of the DCCM array ports. It accepts one store request at a time: address, 4-bit byte enable and 32-bit data. Partial-word stores are turned into a read, an ECC check/correct, a byte merge, an ECC re-encode and a full 39-bit write. Full-word stores skip the read, are encoded and written directly. It drives the `dccm_rden` / `dccm_rd_addr_lo` / `dccm_wren` / `dccm_wr_addr_lo` / `dccm_wr_data_lo` side of the memory wrapper and consumes `dccm_rd_data_lo`.

## Interface

Parameters:
- DCCM_BITS, 16, byte-address width of the DCCM.
- DCCM_DATA_WIDTH, 32, data bits per word.
- DCCM_ECC_WIDTH, 7, SECDED check bits per word.
- DCCM_FDATA_WIDTH, 39, stored word width (data + ECC).

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  store request valid.
- req_ready  out  1  sequencer can accept a request.
- req_addr  in  DCCM_BITS  byte address; bits [1:0] are ignored (word aligned).
- req_byteen  in  4  byte enables; 0 is illegal.
- req_data  in  32  store data, byte lanes in place.
- ecc_disable  in  1  from `dec_tlu_core_ecc_disable`: skip check/correct, still encode.
- dccm_grant  in  1  array port is available this cycle; the core has priority.
- dccm_rden  out  1  array read enable.
- dccm_rd_addr  out  DCCM_BITS  read address.
- dccm_rd_data  in  DCCM_FDATA_WIDTH  read data, valid the cycle after `dccm_rden`.
- dccm_wren  out  1  array write enable.
- dccm_wr_addr  out  DCCM_BITS  write address.
- dccm_wr_data  out  DCCM_FDATA_WIDTH  encoded write data: {ecc[6:0], data[31:0]}.
- sb_err  out  1  one-cycle pulse: single-bit error corrected during RMW.
- db_err  out  1  one-cycle pulse: double-bit error; store dropped.
- busy  out  1  state is not IDLE.

## Operation

- States: IDLE, RD, CHK, WR.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, capture addr, byteen and data.
  - If byteen == 4'hF, go to WR; else go to RD.
- RD:
  - `dccm_rden` = `dccm_grant`; `dccm_rd_addr` = captured addr.
  - If `dccm_grant`, go to CHK; else stay in RD.
- CHK:
  - Sample `dccm_rd_data` and decode it.
  - If `ecc_disable`, use raw data[31:0].
  - Single-bit error: use the corrected data and pulse `sb_err`.
  - Double-bit error: pulse `db_err`, return to IDLE, no write.
  - Otherwise merge: each byte i takes req_data when byteen[i] is set, else the read byte. Register the merged word and go to WR.
- WR:
  - `dccm_wren` = `dccm_grant`; address = captured addr; data = encode(word).
  - If `dccm_grant`, go to IDLE; else hold with all write outputs stable.
- Outputs hold value when not enabled. Address and data outputs are 0 after reset until first use.
- Reset: state goes to IDLE; `dccm_rden`, `dccm_wren`, `sb_err`, `db_err` and `busy` are 0; captured registers are 0; `req_ready` = 1 the cycle after reset deasserts.
- Reset mid-operation abandons the operation. No partial write is ever issued, because write enable is only asserted combinationally in WR.
- Only one request can be in flight; `req_ready` is low outside IDLE.

## Timing

- Full-word store, grant held: accept in cycle 0, `dccm_wren` in cycle 1, `req_ready` again in cycle 2.
- Partial store, grant held:
  - Accept in cycle 0.
  - `dccm_rden` in cycle 1.
  - CHK in cycle 2: read data consumed; `sb_err` / `db_err` asserted here.
  - `dccm_wren` in cycle 3.
  - `req_ready` again in cycle 4.
- Each cycle with `dccm_grant` = 0 in RD or WR adds exactly one cycle. CHK ignores `dccm_grant`.
- `dccm_rden` and `dccm_wren` are never high together.
- A request in the same cycle as `rst` is not accepted.

## Structure

- Shared package `eh2_dccm_rmw_pkg`:
  - State enum {IDLE, RD, CHK, WR}.
  - ECC width constants.
- One sub-module, `eh2_dccm_secded`: combinational 32-bit SECDED encode plus decode/correct, with `single_err` / `double_err` outputs. It is instantiated once for decode (CHK) and once for encode (WR output path).

## Test plan

- Full-word store: addr 0x0040, byteen 4'hF, data 0xDEADBEEF, grant=1 -> cycle 1 `dccm_wren`=1, addr 0x0040, wr_data = {encode_ecc(0xDEADBEEF), 0xDEADBEEF}; no `dccm_rden`.
- Partial store: memory word at 0x0080 = 0x11223344 (clean ECC); store byteen 4'b0010, data 0x0000AA00 -> rden in cycle 1, wren in cycle 3 with data 0x1122AA44 and correct ECC.
- Single-bit error: read data has bit 5 flipped, byteen 4'b0001, data 0xFF -> `sb_err` pulse in cycle 2; written word is the corrected original with low byte 0xFF.
- Double-bit error: bits 3 and 9 flipped -> `db_err` pulse in cycle 2, no `dccm_wren`, `req_ready`=1 in cycle 3. With `ecc_disable`=1 the same data is merged raw with no error pulses.
- Grant stall: partial store with `dccm_grant` low for 2 cycles in RD and 3 cycles in WR -> wren in cycle 8; outputs stable during stalls; `rden` and `wren` never overlap.
- Reset in CHK: assert `rst` in cycle 2 of a partial store -> no `dccm_wren` is ever issued, all outputs at reset values, and the next request is processed normally.
